// File: rtl/srio_db_pkg.sv
// Shared constants, packet field positions and FSM state type for the SRIO
// outbound doorbell path.
package srio_db_pkg;

    localparam logic [7:0] FTYPE_DOORBELL = 8'hA0;
    localparam logic [7:0] RESP_NODATA    = 8'hD0;

    localparam int TID_MSB  = 63;
    localparam int TID_LSB  = 56;
    localparam int TYPE_MSB = 55;
    localparam int TYPE_LSB = 48;
    localparam int PRIO_MSB = 46;
    localparam int PRIO_LSB = 45;
    localparam int INFO_MSB = 31;
    localparam int INFO_LSB = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RESP
    } state_e;

    function automatic logic [63:0] db_packet(input logic [7:0]  tid,
                                              input logic [1:0]  prio,
                                              input logic [15:0] info);
        logic [63:0] pkt;
        pkt                     = '0;
        pkt[TID_MSB:TID_LSB]    = tid;
        pkt[TYPE_MSB:TYPE_LSB]  = FTYPE_DOORBELL;
        pkt[PRIO_MSB:PRIO_LSB]  = prio;
        pkt[INFO_MSB:INFO_LSB]  = info;
        return pkt;
    endfunction

endpackage

// File: rtl/db_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr_i,
// wrapping around. The pointer register is owned by the caller.
module db_rr_arbiter #(
    parameter int C_NUM_REQ = 4,
    localparam int IW = $clog2(C_NUM_REQ)
) (
    input  logic [C_NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]        ptr_i,
    input  logic                 enable_i,
    output logic [C_NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]        grant_idx_o
);

    logic          found;
    logic [IW-1:0] idx;

    // NOTE: every output and temporary gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int k = 1; k <= C_NUM_REQ; k++) begin
            idx = IW'((int'(ptr_i) + k) % C_NUM_REQ);
            if (enable_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/db_tx_scheduler.sv
// Outbound doorbell scheduler: arbitrates local requesters onto the SRIO ireq
// port, matches iresp by TID and retries on timeout or error response.
module db_tx_scheduler
    import srio_db_pkg::*;
#(
    parameter int          C_NUM_REQ      = 4,
    parameter logic [15:0] C_SRIO_DEV_ID  = 16'hF201,
    parameter logic [15:0] C_SRIO_DEST_ID = 16'h7801,
    parameter logic [1:0]  C_PRIO         = 2'b01,
    parameter int          C_TIMEOUT      = 1024,
    parameter int          C_MAX_RETRY    = 3
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [C_NUM_REQ-1:0]    req_valid,
    input  logic [16*C_NUM_REQ-1:0] req_info,
    output logic [C_NUM_REQ-1:0]    req_ready,
    output logic [C_NUM_REQ-1:0]    req_done,
    output logic [C_NUM_REQ-1:0]    req_err,
    output logic                    busy,
    output logic                    stray_resp,
    output logic                    m_axis_ireq_tvalid,
    input  logic                    m_axis_ireq_tready,
    output logic [63:0]             m_axis_ireq_tdata,
    output logic [7:0]              m_axis_ireq_tkeep,
    output logic                    m_axis_ireq_tlast,
    output logic [31:0]             m_axis_ireq_tuser,
    input  logic                    s_axis_iresp_tvalid,
    output logic                    s_axis_iresp_tready,
    input  logic [63:0]             s_axis_iresp_tdata,
    input  logic [7:0]              s_axis_iresp_tkeep,
    input  logic                    s_axis_iresp_tlast,
    input  logic [31:0]             s_axis_iresp_tuser
);

    localparam int IW = $clog2(C_NUM_REQ);

    state_e        state_q,    state_d;
    logic [7:0]    tid_q,      tid_d;
    logic [7:0]    sent_tid_q, sent_tid_d;
    logic [IW-1:0] ptr_q,      ptr_d;
    logic [IW-1:0] gnt_idx_q,  gnt_idx_d;
    logic [15:0]   info_q,     info_d;
    logic [2:0]    retry_q,    retry_d;
    logic [15:0]   tmo_q,      tmo_d;

    logic [C_NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 resp_match;
    logic                 ireq_active;
    logic                 unused_iresp;

    db_rr_arbiter #(.C_NUM_REQ(C_NUM_REQ)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .enable_i    ((state_q == IDLE) && !areset),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx)
    );

    // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            tid_q      <= '0;
            sent_tid_q <= '0;
            ptr_q      <= IW'(C_NUM_REQ - 1);
            gnt_idx_q  <= '0;
            info_q     <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            tid_q      <= tid_d;
            sent_tid_q <= sent_tid_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            info_q     <= info_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tid_d      = tid_q;
        sent_tid_d = sent_tid_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        info_d     = info_q;
        retry_d    = retry_q;
        tmo_d      = tmo_q;
        req_ready  = '0;
        req_done   = '0;
        req_err    = '0;

        resp_match = s_axis_iresp_tvalid && (state_q == WAIT_RESP) &&
                     (s_axis_iresp_tdata[TID_MSB:TID_LSB] == sent_tid_q);
        stray_resp = s_axis_iresp_tvalid && !resp_match && !areset;

        case (state_q)
            IDLE: begin
                if (|arb_grant) begin
                    for (int i = 0; i < C_NUM_REQ; i++) begin
                        if (arb_grant[i]) info_d = req_info[16*i +: 16];
                    end
                    gnt_idx_d = arb_idx;
                    ptr_d     = arb_idx;
                    req_ready = arb_grant;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (m_axis_ireq_tready) begin
                    sent_tid_d = tid_q;
                    tid_d      = tid_q + 8'd1;
                    tmo_d      = '0;
                    state_d    = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                tmo_d = tmo_q + 16'd1;
                // A matched response outranks a coincident timeout.
                if (resp_match && s_axis_iresp_tdata[TYPE_MSB:TYPE_LSB] == RESP_NODATA) begin
                    req_done[gnt_idx_q] = 1'b1;
                    retry_d             = '0;
                    state_d             = IDLE;
                end else if (resp_match || tmo_q == 16'(C_TIMEOUT - 1)) begin
                    if (retry_q < 3'(C_MAX_RETRY)) begin
                        retry_d = retry_q + 3'd1;
                        state_d = SEND;
                    end else begin
                        req_err[gnt_idx_q] = 1'b1;
                        retry_d            = '0;
                        state_d            = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (areset) begin
            req_done = '0;
            req_err  = '0;
        end
    end

    assign ireq_active         = (state_q == SEND) && !areset;
    assign m_axis_ireq_tvalid  = ireq_active;
    assign m_axis_ireq_tdata   = ireq_active ? db_packet(tid_q, C_PRIO, info_q) : '0;
    assign m_axis_ireq_tkeep   = ireq_active ? 8'hFF : 8'h00;
    assign m_axis_ireq_tlast   = ireq_active;
    assign m_axis_ireq_tuser   = ireq_active ? {C_SRIO_DEV_ID, C_SRIO_DEST_ID} : '0;
    assign busy                = (state_q != IDLE) && !areset;
    assign s_axis_iresp_tready = 1'b1;

    assign unused_iresp = ^{s_axis_iresp_tdata[47:0], s_axis_iresp_tkeep,
                            s_axis_iresp_tlast, s_axis_iresp_tuser};

endmodule

// File: tb/tb_db_tx_scheduler.sv
// Self-checking bench for db_tx_scheduler: directed scenarios plus randomized
// doorbells checked against a transaction-level model of grant order and TIDs.
module tb_db_tx_scheduler;

    localparam int N    = 4;
    localparam int TMO  = 16;
    localparam int MAXR = 2;

    logic          aclk;
    logic          areset;
    logic [N-1:0]  req_valid;
    logic [16*N-1:0] req_info;
    logic [N-1:0]  req_ready, req_done, req_err;
    logic          busy, stray_resp;
    logic          m_tvalid, m_tready, m_tlast;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep;
    logic [31:0]   m_tuser;
    logic          s_tvalid, s_tready, s_tlast;
    logic [63:0]   s_tdata;
    logic [7:0]    s_tkeep;
    logic [31:0]   s_tuser;

    int n_cmp = 0;
    int n_err = 0;
    int tid_m = 0;
    int ptr_m = N - 1;

    db_tx_scheduler #(
        .C_NUM_REQ   (N),
        .C_TIMEOUT   (TMO),
        .C_MAX_RETRY (MAXR)
    ) dut (
        .aclk                (aclk),
        .areset              (areset),
        .req_valid           (req_valid),
        .req_info            (req_info),
        .req_ready           (req_ready),
        .req_done            (req_done),
        .req_err             (req_err),
        .busy                (busy),
        .stray_resp          (stray_resp),
        .m_axis_ireq_tvalid  (m_tvalid),
        .m_axis_ireq_tready  (m_tready),
        .m_axis_ireq_tdata   (m_tdata),
        .m_axis_ireq_tkeep   (m_tkeep),
        .m_axis_ireq_tlast   (m_tlast),
        .m_axis_ireq_tuser   (m_tuser),
        .s_axis_iresp_tvalid (s_tvalid),
        .s_axis_iresp_tready (s_tready),
        .s_axis_iresp_tdata  (s_tdata),
        .s_axis_iresp_tkeep  (s_tkeep),
        .s_axis_iresp_tlast  (s_tlast),
        .s_axis_iresp_tuser  (s_tuser)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_resp(input logic [7:0] tid, input logic [7:0] typ);
        s_tvalid = 1'b1;
        s_tdata  = {tid, typ, 48'h0};
        s_tkeep  = 8'hFF;
        s_tlast  = 1'b1;
    endtask

    task automatic clear_resp();
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
    endtask

    function automatic int next_grant(input logic [N-1:0] vmask);
        for (int k = 1; k <= N; k++)
            if (vmask[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return -1;
    endfunction

    // One doorbell from request to done/err. n_fail attempts fail (timeout or error
    // response); the attempt after that succeeds after 'delay' wait cycles.
    task automatic transact(input logic [N-1:0] vmask, input logic [16*N-1:0] infos,
                            input int bp, input int n_fail, input int delay,
                            input bit tmo_only, input bit stray);
        int         g, d;
        logic [N-1:0] oh;
        logic [7:0] sent, etype;
        logic [63:0] pkt;
        bit         err_rsp;
        req_valid = vmask;
        req_info  = infos;
        g  = next_grant(vmask);
        oh = N'(1 << g);
        @(negedge aclk);
        check("req_ready", req_ready, oh);
        ptr_m = g;
        step();
        req_valid = vmask & ~oh;
        for (int a = 0; a <= n_fail && a <= MAXR; a++) begin
            pkt = {tid_m[7:0], 8'hA0, 16'h2000, infos[16*g +: 16], 16'h0000};
            for (int b = 0; b <= bp; b++) begin
                m_tready = (b == bp);
                @(negedge aclk);
                check("ireq_tvalid", m_tvalid, 1);
                check("ireq_tdata", m_tdata, pkt);
                check("ireq_tuser", m_tuser, 32'hF201_7801);
                if (b == 0) check("ireq_tkeep_tlast", {m_tkeep, m_tlast}, {8'hFF, 1'b1});
                step();
            end
            sent  = tid_m[7:0];
            tid_m = (tid_m + 1) % 256;
            if (a < n_fail) begin
                err_rsp = !tmo_only && ($urandom_range(1) == 1);
                d = err_rsp ? int'($urandom_range(TMO - 1)) : TMO - 1;
                etype = 8'($urandom_range(255));
                if (etype == 8'hD0) etype = 8'hD1;
                for (int c = 0; c <= d; c++) begin
                    if (c == d && err_rsp) drive_resp(sent, etype);
                    @(negedge aclk);
                    check("wait_tvalid", m_tvalid, 0);
                    if (c == d) begin
                        check("req_err", req_err, (a == MAXR) ? oh : '0);
                        check("req_done_fail", req_done, 0);
                    end
                    step();
                    clear_resp();
                end
            end else begin
                for (int c = 0; c <= delay; c++) begin
                    if (stray && c == 0) drive_resp(sent ^ 8'h0C, 8'hD0);
                    if (c == delay) drive_resp(sent, 8'hD0);
                    @(negedge aclk);
                    if (stray && c == 0) begin
                        check("stray_resp", stray_resp, 1);
                        check("stray_busy_done", {busy, req_done}, {1'b1, 4'h0});
                    end
                    if (c == delay) begin
                        check("req_done", req_done, oh);
                        check("done_err_stray", {req_err, stray_resp}, 0);
                    end
                    step();
                    clear_resp();
                end
            end
        end
        req_valid = '0;
        @(negedge aclk);
        check("idle_after", {busy, req_done, req_err}, 0);
        step();
    endtask

    initial begin
        logic [N-1:0] vm;
        logic [7:0]   sent;
        int           nf, dl, bp;
        bit           st;

        areset    = 1'b1;
        req_valid = '0;
        req_info  = '0;
        m_tready  = 1'b1;
        clear_resp();
        step();
        step();
        @(negedge aclk);
        check("reset_outputs", {req_ready, req_done, req_err, busy, stray_resp,
                                m_tvalid, m_tkeep, m_tlast}, 0);
        check("reset_tdata_tuser", {m_tdata, m_tuser}, 0);
        check("reset_iresp_tready", s_tready, 1);
        step();
        areset = 1'b0;

        // Single request, answered in the first wait cycle.
        transact(4'b0001, 64'h0000_0000_0000_1234, 0, 0, 0, 1'b0, 1'b0);
        // Backpressure for 5 cycles.
        transact(4'b0010, 64'h0000_0000_BEEF_0000, 5, 0, 2, 1'b0, 1'b0);
        // Stray response before the real one.
        transact(4'b0100, 64'h0000_CAFE_0000_0000, 0, 0, 3, 1'b0, 1'b1);
        // Timeouts until the retry budget is exhausted.
        transact(4'b0001, 64'h0000_0000_0000_5A5A, 0, MAXR + 1, 0, 1'b1, 1'b0);
        // Response coincident with the timeout cycle wins.
        transact(4'b1000, 64'h7777_0000_0000_0000, 0, 0, TMO - 1, 1'b0, 1'b0);

        for (int it = 0; it < 25; it++) begin
            vm = N'($urandom_range(1, 15));
            bp = $urandom_range(3);
            nf = $urandom_range(MAXR + 1);
            dl = $urandom_range(TMO - 1);
            st = (dl >= 1) && ($urandom_range(3) == 0);
            transact(vm, {$urandom, $urandom}, bp, nf, dl, 1'b0, st);
        end

        // Reset while waiting for a response.
        req_valid = 4'b0001;
        req_info  = 64'h0000_0000_0000_ABCD;
        @(negedge aclk);
        check("rst_req_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        @(negedge aclk);
        check("rst_tvalid", m_tvalid, 1);
        step();
        sent   = tid_m[7:0];
        areset = 1'b1;
        drive_resp(sent, 8'hD0);
        @(negedge aclk);
        check("rst_mid_outputs", {req_ready, req_done, req_err, busy, stray_resp,
                                  m_tvalid, m_tkeep, m_tlast}, 0);
        check("rst_mid_iresp_tready", s_tready, 1);
        step();
        areset = 1'b0;
        clear_resp();
        tid_m = 0;
        ptr_m = N - 1;
        @(negedge aclk);
        check("rst_after_busy", {busy, req_done, req_err}, 0);
        step();
        drive_resp(sent, 8'hD0);
        @(negedge aclk);
        check("late_resp_stray", stray_resp, 1);
        check("late_resp_no_done", {req_done, req_err}, 0);
        step();
        clear_resp();

        // Round robin with all requesters asking: order 0,1,2,3,0 with TIDs 00..04.
        for (int i = 0; i < 5; i++)
            transact(4'b1111, 64'h4444_3333_2222_1111, 0, 0, 0, 1'b0, 1'b0);
        check("rr_final_tid", 64'(tid_m), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
